// File: rtl/p_common.sv
// Shared ALU types: preshift descriptor, result-source tag and output-register state.
package p_common;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  // Encodings 5..7 are reserved; the preshifter passes data through for them.
  typedef enum logic [2:0] {
    SHIFT_NONE = 3'd0,
    SHIFT_SHL  = 3'd1,
    SHIFT_SHR  = 3'd2,
    SHIFT_ASL  = 3'd3,
    SHIFT_ASR  = 3'd4
  } e_shift_type;

  typedef struct packed {
    e_shift_type        typ;
    logic [SHAMT_W-1:0] amt;
  } s_shift;

  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_AGU = 1'b1
  } e_shift_src;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } e_res_state;

endpackage

// File: rtl/m_alu_preshifter.sv
// Combinational preshifter: SHL/ASL, SHR, ASR by amt; reserved types pass data unchanged.
// Zero latency, no flow control.
module m_alu_preshifter
  import p_common::*;
(
  input  logic [DATA_W-1:0] data,
  input  s_shift            shift,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = data;
    case (shift.typ)
      SHIFT_SHL, SHIFT_ASL: result = data << shift.amt;
      SHIFT_SHR:            result = data >> shift.amt;
      SHIFT_ASR:            result = $unsigned($signed(data) >>> shift.amt);
      default:              result = data;
    endcase
  end

endmodule

// File: rtl/m_alu_shift_arbiter.sv
// Two-requester arbiter into one shared preshifter with a one-entry result register; 1-cycle latency,
// accepts only when the register is empty or draining. ALU_SHIFT_ARB_RR_EN selects round-robin ties.
module m_alu_shift_arbiter
  import p_common::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  s_shift           req0_shift,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  s_shift           req1_shift,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output e_shift_src       res_src,
  output logic [TAG_W-1:0] res_tag
);

  e_res_state       state;
  e_shift_src       grant;
  logic             can_accept;
  logic             accept;
  logic [31:0]      sel_data;
  s_shift           sel_shift;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      shift_res;

`ifdef ALU_SHIFT_ARB_RR_EN
  e_shift_src last_grant;

  always_comb begin
    grant = SRC_EX;
    if (req0_valid && req1_valid)
      grant = (last_grant == SRC_EX) ? SRC_AGU : SRC_EX;
    else if (req1_valid)
      grant = SRC_AGU;
  end
`else
  always_comb begin
    grant = SRC_EX;
    if (!req0_valid && req1_valid)
      grant = SRC_AGU;
  end
`endif

  // Grant never looks at res_ready; only the accept window does.
  assign can_accept = !rst && ((state == ST_EMPTY) || res_ready);
  assign accept     = can_accept && (req0_valid || req1_valid);
  assign req0_ready = can_accept && (grant == SRC_EX);
  assign req1_ready = can_accept && (grant == SRC_AGU);

  always_comb begin
    sel_data  = req0_data;
    sel_shift = req0_shift;
    sel_tag   = req0_tag;
    if (grant == SRC_AGU) begin
      sel_data  = req1_data;
      sel_shift = req1_shift;
      sel_tag   = req1_tag;
    end
  end

  m_alu_preshifter u_preshifter (
    .data   (sel_data),
    .shift  (sel_shift),
    .result (shift_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_src   <= SRC_EX;
      res_tag   <= '0;
`ifdef ALU_SHIFT_ARB_RR_EN
      last_grant <= SRC_AGU;
`endif
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_FULL;
            res_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (res_ready && !accept) begin
            state     <= ST_EMPTY;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          res_valid <= 1'b0;
        end
      endcase
      // accept implies the register is empty or draining, so reloading here never clobbers a held result.
      if (accept) begin
        res_data <= shift_res;
        res_src  <= grant;
        res_tag  <= sel_tag;
`ifdef ALU_SHIFT_ARB_RR_EN
        last_grant <= grant;
`endif
      end
    end
  end

endmodule

// File: tb/tb_m_alu_shift_arbiter.sv
// Directed bench for m_alu_shift_arbiter with a result scoreboard and a small grant model.
module tb_m_alu_shift_arbiter;
  import p_common::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [31:0]      req0_data;
  s_shift           req0_shift;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [31:0]      req1_data;
  s_shift           req1_shift;
  logic [TAG_W-1:0] req1_tag;
  logic             res_valid, res_ready;
  logic [31:0]      res_data;
  e_shift_src       res_src;
  logic [TAG_W-1:0] res_tag;

  typedef struct packed {
    logic [31:0]      data;
    logic             src;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   last_g = 1;

  always #5 clk = ~clk;

  m_alu_shift_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shift (req0_shift),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shift (req1_shift),
    .req1_tag   (req1_tag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_src    (res_src),
    .res_tag    (res_tag)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic v0, input logic v1);
`ifdef ALU_SHIFT_ARB_RR_EN
    if (v0 && v1) return (last_g == 0) ? 1 : 0;
`endif
    if (v0) return 0;
    if (v1) return 1;
    return 0;
  endfunction

  task automatic chk_ready(input string name, input bit can_acc);
    int g;
    g = pick(req0_valid, req1_valid);
    chk({name, "_rdy0"}, {31'd0, req0_ready}, {31'd0, can_acc && (g == 0)});
    chk({name, "_rdy1"}, {31'd0, req1_ready}, {31'd0, can_acc && (g == 1)});
  endtask

  task automatic push_exp(input logic [31:0] d, input int g, input logic [TAG_W-1:0] t);
    exp_t e;
    e.data = d;
    e.src  = (g == 1);
    e.tag  = t;
    exp_q.push_back(e);
    last_g = g;
  endtask

  task automatic chk_res(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      ntests++;
      nfail++;
      $error("FAIL %s scoreboard empty observed_valid=%0b expected=queued_result", name, res_valid);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_vld"},  {31'd0, res_valid}, 32'd1);
      chk({name, "_data"}, res_data, e.data);
      chk({name, "_src"},  {31'd0, res_src}, {31'd0, e.src});
      chk({name, "_tag"},  {28'd0, res_tag}, {28'd0, e.tag});
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = '0; req0_shift = '0; req0_tag = '0;
    req1_valid = 1'b1; req1_data = '0; req1_shift = '0; req1_tag = '0;
    res_ready = 1'b0;
    #3;
    chk("rst_vld",  {31'd0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_src",  {31'd0, res_src}, 32'd0);
    chk("rst_tag",  {28'd0, res_tag}, 32'd0);
    chk_ready("rst", 1'b0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single req0: 0xF0 << 4, tag 3
    req0_valid = 1'b1; req0_data = 32'h0000_00F0;
    req0_shift.typ = SHIFT_SHL; req0_shift.amt = 5'd4; req0_tag = 4'd3;
    res_ready = 1'b1;
    #1 chk_ready("single", 1'b1);
    push_exp(32'h0000_0F00, 0, 4'd3);
    tick();
    req0_valid = 1'b0;
    #1 chk_res("single");
    tick();
    chk("single_drain", {31'd0, res_valid}, 32'd0);

    // Reserved shift encoding passes data through
    req1_valid = 1'b1; req1_data = 32'h1234_5678;
    req1_shift.typ = e_shift_type'(3'd7); req1_shift.amt = 5'd3; req1_tag = 4'd2;
    #1 chk_ready("unk", 1'b1);
    push_exp(32'h1234_5678, 1, 4'd2);
    tick();
    req1_valid = 1'b0;
    #1 chk_res("unk");
    tick();
    chk("unk_drain", {31'd0, res_valid}, 32'd0);

    // Backpressure: fill, stall three cycles with req1 waiting, then drain and accept together
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0000_000F;
    req0_shift.typ = SHIFT_ASL; req0_shift.amt = 5'd4; req0_tag = 4'd1;
    #1 chk_ready("bp_fill", 1'b1);
    push_exp(32'h0000_00F0, 0, 4'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h8000_0000;
    req1_shift.typ = SHIFT_ASR; req1_shift.amt = 5'd8; req1_tag = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ready("bp_stall", 1'b0);
      chk("bp_hold_vld",  {31'd0, res_valid}, 32'd1);
      chk("bp_hold_data", res_data, 32'h0000_00F0);
      chk("bp_hold_tag",  {28'd0, res_tag}, 32'd1);
      tick();
    end
    res_ready = 1'b1;
    #1 chk_ready("bp_release", 1'b1);
    chk_res("bp_first");
    push_exp(32'hFF80_0000, 1, 4'd7);
    tick();
    req1_valid = 1'b0;
    res_ready = 1'b0;
    #1 chk_res("bp_second");

    // Reset while FULL, between clock edges
    tick();
    chk("rstfull_pre", {31'd0, res_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstfull_vld",  {31'd0, res_valid}, 32'd0);
    chk("rstfull_data", res_data, 32'd0);
    chk("rstfull_tag",  {28'd0, res_tag}, 32'd0);
    chk_ready("rstfull", 1'b0);
    rst = 1'b0;
    last_g = 1;

    // Both requesters valid continuously
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h0000_0001;
    req0_shift.typ = SHIFT_SHL; req0_shift.amt = 5'd1; req0_tag = 4'd5;
    req1_valid = 1'b1; req1_data = 32'h0000_0100;
    req1_shift.typ = SHIFT_SHR; req1_shift.amt = 5'd4; req1_tag = 4'd9;
    for (int i = 0; i < 4; i++) begin
      int g;
      #1;
      chk_ready("tie", 1'b1);
      g = pick(1'b1, 1'b1);
      if (g == 0) push_exp(32'h0000_0002, 0, 4'd5);
      else        push_exp(32'h0000_0010, 1, 4'd9);
      tick();
      chk_res("tie");
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 chk_ready("idle", 1'b1);
    tick();
    chk("tie_drain", {31'd0, res_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/m_alu_shift_arbiter.md
M_ALU_SHIFT_ARBITER -- requirements
Module: m_alu_shift_arbiter

Interface
REQ-001 SHALL have parameter: TAG_W, 4, width of the per-request tag passed through unchanged.
REQ-002 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid in 1, req0_ready out 1, req0_data in 32, req0_shift in s_shift, req0_tag in TAG_W; requester 0 (execute stage).
REQ-005 SHALL have ports: req1_valid in 1, req1_ready out 1, req1_data in 32, req1_shift in s_shift, req1_tag in TAG_W; requester 1 (address generation).
REQ-006 SHALL have ports: res_valid out 1, res_ready in 1, res_data out 32, res_src out 1 (0=req0, 1=req1), res_tag out TAG_W; registered result.

Function
REQ-007 SHALL share one preshifter between both requesters; transfer on a port occurs when valid and ready are both high at a rising edge.
REQ-008 SHALL hold a one-entry output register with states EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-009 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on res_ready with no accept; FULL->FULL on res_ready with simultaneous accept (register reloaded); FULL holds contents while res_ready=0.
REQ-010 SHALL accept a new request only when state is EMPTY or res_ready=1 (can_accept).
REQ-011 SHALL compute grant from req0_valid, req1_valid and last_grant only, never from res_ready.
REQ-012 SHALL grant the sole valid requester when only one is valid.
REQ-013 SHALL, when both are valid, grant the requester not equal to last_grant (round-robin).
REQ-014 SHALL drive reqN_ready = can_accept AND grant==N; at most one ready high per cycle; ready low for a non-granted requester.
REQ-015 SHALL update last_grant only on an accepted transfer.
REQ-016 SHALL load res_data with the s_shift result of the granted data (SHL, SHR, ASL, ASR; any other type passes data unchanged), res_src with grant, res_tag with the granted tag.
REQ-017 SHALL have latency of exactly one cycle: accept at edge N -> res_valid high after edge N.
REQ-018 SHALL sustain one result per cycle when res_ready held high.
REQ-019 SHALL keep res_data/res_src/res_tag stable while res_valid=1 and res_ready=0.
REQ-020 SHALL never drop or duplicate a request; requesters hold valid and payload stable until accepted.

Reset
REQ-021 SHALL on rst assertion immediately force res_valid=0, res_data=0, res_src=0, res_tag=0, last_grant=1 (req0 wins first tie), state EMPTY.
REQ-022 SHALL discard a FULL result when reset is asserted mid-operation; both readies low while rst=1.

Configuration
REQ-023 SHALL support macro ALU_SHIFT_ARB_RR_EN: defined -> round-robin per REQ-013; undefined -> fixed priority, req0 always wins ties and last_grant is not implemented.

Structure
REQ-024 SHALL take s_shift and shift-type enums from p_common; SHALL add to p_common an enum e_shift_src (SRC_EX=0, SRC_AGU=1) used for res_src.
REQ-025 SHALL instantiate m_alu_preshifter as its sole sub-module, on the granted operand (mux before shifter, register after).

Verification
REQ-026 Single req0: data=0x0000_00F0, SHL 4, tag=3, res_ready=1 -> next cycle res_valid=1, res_data=0x0000_0F00, res_src=0, res_tag=3.
REQ-027 Both valid continuously after reset, res_ready=1, RR_EN defined -> grants 0,1,0,1; without macro -> grants 0,0,0,0 and req1_ready never high.
REQ-028 Backpressure: FULL with res_ready=0 for 3 cycles, req1 valid ASR 8 on 0x8000_0000 -> both readies low, res held; res_ready=1 -> simultaneous drain and accept, next res_data=0xFF80_0000.
REQ-029 Unknown shift_type on 0x1234_5678 -> res_data=0x1234_5678.
REQ-030 rst pulsed while FULL, no clock edge -> res_valid falls immediately; after release, first tie grants req0.
